// File: rtl/enc_pkg.sv
// Shared types and constants for the LFSR encrypter: FSM state encoding,
// the maximal-length 5-bit tap table and helpers for tap lookup and byte encryption.
package enc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRE,
    MSG,
    FIN,
    ERR
  } enc_state_t;

  localparam int         NUM_TAPS    = 6;
  localparam logic [3:0] MIN_PRE_LEN = 4'd5;
  localparam logic [2:0] MAX_TAP_SEL = 3'(NUM_TAPS - 1);

  localparam logic [4:0] LFSR_TAPS [NUM_TAPS] = '{
    5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h14, 5'h12
  };

  // Out-of-range selections return an all-zero pattern; the FSM rejects them anyway.
  function automatic logic [4:0] tap_lookup(input logic [2:0] sel);
    logic [4:0] t;
    t = 5'h00;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (sel == 3'(i)) t = LFSR_TAPS[i];
    end
    return t;
  endfunction

  function automatic logic [7:0] enc_byte(input logic [7:0] x, input logic [4:0] s);
    return {x[7:5], x[4:0] ^ s};
  endfunction

endpackage

// File: rtl/lfsr_encrypter_if.sv
// Data-memory port bundle between the encrypter (master) and dat_mem (slave).
// The read path is combinational: data_out follows raddr within the same cycle.
interface lfsr_encrypter_if;
  logic [7:0] raddr;
  logic [7:0] data_out;
  logic       wr_en;
  logic [7:0] waddr;
  logic [7:0] data_in;

  modport master (
    output raddr,
    output wr_en,
    output waddr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  raddr,
    input  wr_en,
    input  waddr,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/lfsr5.sv
// 5-bit Fibonacci-style LFSR: shifts left, feedback is the parity of the tapped bits.
// init loads the start value and takes priority over en.
module lfsr5 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       init,
  input  logic [4:0] taps,
  input  logic [4:0] start,
  output logic [4:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= 5'h00;
    end else if (init) begin
      state <= start;
    end else if (en) begin
      state <= {state[3:0], ^(state & taps)};
    end
  end

endmodule

// File: rtl/lfsr_encrypter.sv
// Reads plaintext from dat_mem, prepends a preamble, XORs the low 5 bits of each
// byte with an LFSR keystream and writes the ciphertext block back to dat_mem.
//
// state | meaning
// IDLE  | waiting for init after reset
// LOAD  | latch parameters, load LFSR with seed, validate configuration
// PRE   | write pre_len encrypted preamble bytes
// MSG   | read plaintext byte j, write encrypted byte k
// FIN   | run complete, done held until next init
// ERR   | illegal parameters, err held until next init
module lfsr_encrypter
  import enc_pkg::*;
#(
  parameter int unsigned PT_BASE = 0,
  parameter int unsigned CT_BASE = 64,
  parameter int unsigned LEN     = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init,
  input  logic [7:0]              preamble,
  input  logic [3:0]              pre_len,
  input  logic [2:0]              tap_sel,
  input  logic [4:0]              seed,
  lfsr_encrypter_if.master        mem,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam logic [7:0] PT_B   = 8'(PT_BASE);
  localparam logic [7:0] CT_B   = 8'(CT_BASE);
  localparam logic [7:0] LAST_K = 8'(LEN - 1);

  enc_state_t state;
  logic [7:0] k;
  logic [7:0] j;
  logic       wr_en_q;
  logic [7:0] preamble_q;
  logic [3:0] pre_q;
  logic [4:0] taps_q;
  logic [4:0] lfsr_s;
  logic [7:0] last_pre;
  logic [7:0] src_byte;
  logic [7:0] data_in_c;
  logic       bad_cfg;

  assign last_pre = {4'd0, pre_q} - 8'd1;
  assign bad_cfg  = (tap_sel > MAX_TAP_SEL) || (seed == 5'h00) || (pre_len < MIN_PRE_LEN);

  // The keystream advances exactly when a byte is written.
  lfsr5 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wr_en_q),
    .init  (state == LOAD),
    .taps  (taps_q),
    .start (seed),
    .state (lfsr_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= 8'd0;
      j          <= 8'd0;
      wr_en_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      preamble_q <= 8'h00;
      pre_q      <= 4'd0;
      taps_q     <= 5'h00;
    end else if (init) begin
      // init from any state, including mid-run, restarts through LOAD
      state   <= LOAD;
      k       <= 8'd0;
      j       <= 8'd0;
      wr_en_q <= 1'b0;
      busy    <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          preamble_q <= preamble;
          pre_q      <= pre_len;
          taps_q     <= tap_lookup(tap_sel);
          k          <= 8'd0;
          j          <= 8'd0;
          if (bad_cfg) begin
            state <= ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            state   <= PRE;
            wr_en_q <= 1'b1;
          end
        end
        PRE: begin
          k <= k + 8'd1;
          if (k == last_pre) state <= MSG;
        end
        MSG: begin
          k <= k + 8'd1;
          j <= j + 8'd1;
          if (k == LAST_K) begin
            state   <= FIN;
            wr_en_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  always_comb begin
    src_byte  = (state == MSG) ? mem.data_out : preamble_q;
    data_in_c = wr_en_q ? enc_byte(src_byte, lfsr_s) : 8'h00;
  end

  assign mem.raddr   = PT_B + j;
  assign mem.waddr   = CT_B + k;
  assign mem.wr_en   = wr_en_q;
  assign mem.data_in = data_in_c;

endmodule

// File: tb/tb_lfsr_encrypter.sv
// Bench for lfsr_encrypter: a frame-level reference model predicts every write and
// status output per cycle; directed and random runs cover restart, reset and errors.
module tb_lfsr_encrypter;

  localparam int LEN     = 64;
  localparam int CT_BASE = 64;

  typedef logic [7:0] ct_arr_t [LEN];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init = 1'b0;
  logic [7:0] preamble = 8'h00;
  logic [3:0] pre_len = 4'd0;
  logic [2:0] tap_sel = 3'd0;
  logic [4:0] seed = 5'h00;
  logic       busy, done, err;

  lfsr_encrypter_if bus ();

  lfsr_encrypter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (init),
    .preamble (preamble),
    .pre_len  (pre_len),
    .tap_sel  (tap_sel),
    .seed     (seed),
    .mem      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];

  assign bus.data_out = pt_mem[bus.raddr];
  always @(posedge clk) if (bus.wr_en) ct_mem[bus.waddr] <= bus.data_in;

  int      n_checks = 0;
  int      n_fail = 0;
  int      cyc = 0;
  int      t0 = 0;
  logic    m_active = 1'b0;
  logic    m_legal = 1'b0;
  int      m_plen = 0;
  ct_arr_t exp_ct;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] tap_of(input logic [2:0] sel);
    case (sel)
      3'd0: return 5'h1E;
      3'd1: return 5'h1D;
      3'd2: return 5'h1B;
      3'd3: return 5'h17;
      3'd4: return 5'h14;
      3'd5: return 5'h12;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic [4:0] step(input logic [4:0] s, input logic [4:0] t);
    return {s[3:0], ^(s & t)};
  endfunction

  // Whole ciphertext frame: preamble copies followed by plaintext, one key step per byte.
  function automatic ct_arr_t calc_ct(input logic [7:0] p, input int plen,
                                      input logic [4:0] taps, input logic [4:0] sd);
    ct_arr_t    r;
    logic [4:0] s;
    logic [7:0] x;
    s = sd;
    for (int i = 0; i < LEN; i++) begin
      x    = (i < plen) ? p : pt_mem[i - plen];
      r[i] = {x[7:5], x[4:0] ^ s};
      s    = step(s, taps);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_active <= 1'b0;
    end else if (init) begin
      t0       <= cyc + 1;
      m_active <= 1'b1;
      m_legal  <= (tap_sel <= 3'd5) && (seed != 5'h00) && (pre_len >= 4'd5);
      m_plen   <= int'(pre_len);
      exp_ct   <= calc_ct(preamble, int'(pre_len), tap_of(tap_sel), seed);
    end
  end

  // d = 1 is the LOAD cycle, writes k = 0..LEN-1 occur at d = k + 2.
  always @(negedge clk) begin
    int d;
    int k;
    if (!rst_n || !m_active) begin
      chk("idle_wr_en", bus.wr_en, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_err", err, 0);
      chk("idle_raddr", bus.raddr, 0);
      chk("idle_waddr", bus.waddr, CT_BASE);
      chk("idle_data_in", bus.data_in, 0);
    end else begin
      d = cyc - t0 + 1;
      k = d - 2;
      if (m_legal) begin
        chk("busy", busy, (d >= 1 && d <= LEN + 1));
        chk("wr_en", bus.wr_en, (d >= 2 && d <= LEN + 1));
        chk("done", done, (d >= LEN + 2));
        chk("err", err, 0);
        if (d >= 2 && d <= LEN + 1) begin
          chk("waddr", bus.waddr, CT_BASE + k);
          chk("data_in", bus.data_in, exp_ct[k]);
          if (k >= m_plen) chk("raddr", bus.raddr, k - m_plen);
        end
      end else begin
        chk("bad_busy", busy, (d == 1));
        chk("bad_err", err, (d >= 2));
        chk("bad_done", done, 0);
        chk("bad_wr_en", bus.wr_en, 0);
      end
    end
  end

  task automatic pulse_init(input logic [7:0] p, input logic [3:0] pl,
                            input logic [2:0] ts, input logic [4:0] sd);
    preamble = p;
    pre_len  = pl;
    tap_sel  = ts;
    seed     = sd;
    init     = 1'b1;
    @(posedge clk);
    #2 init = 1'b0;
    @(posedge clk);
    #2;
    preamble = 8'($urandom);
    pre_len  = 4'($urandom);
    tap_sel  = 3'($urandom);
    seed     = 5'($urandom);
  endtask

  task automatic wait_end(output int n);
    n = 0;
    for (int i = 0; i < LEN + 20; i++) begin
      @(negedge clk);
      n++;
      if (done || err) return;
    end
    n = -1;
  endtask

  task automatic check_image(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < LEN; i++) if (ct_mem[CT_BASE + i] !== exp_ct[i]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic decrypt_check(input logic [7:0] p, input int plen, input logic [4:0] taps);
    logic [4:0] s;
    logic [7:0] x, r, e;
    int         bad;
    bad = 0;
    s = ct_mem[CT_BASE][4:0] ^ p[4:0];
    for (int i = 0; i < LEN; i++) begin
      x = ct_mem[CT_BASE + i];
      r = {x[7:5], x[4:0] ^ s};
      e = (i < plen) ? p : pt_mem[i - plen];
      if (r !== e) bad++;
      s = step(s, taps);
    end
    chk("decrypt", bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    string      msg;
    int         n;
    logic [7:0] rp;
    logic [3:0] rl;
    logic [2:0] rt;
    logic [4:0] rs;
    msg = "Mr. Watson, come here";
    for (int i = 0; i < 256; i++) pt_mem[i] = (i < msg.len()) ? msg[i] : 8'h20;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;

    pulse_init(8'h7E, 4'd7, 3'd0, 5'h01);
    wait_end(n);
    chk("done_latency", n, LEN + 1);
    chk("model_pin0", exp_ct[0], 8'h7F);
    chk("model_pin1", exp_ct[1], 8'h7C);
    chk("model_pin2", exp_ct[2], 8'h7B);
    chk("mem64", ct_mem[64], 8'h7F);
    chk("mem65", ct_mem[65], 8'h7C);
    chk("mem66", ct_mem[66], 8'h7B);
    check_image("image_pre");

    for (int ts = 0; ts < 6; ts++) begin
      pulse_init(8'h7E, 4'd7, 3'(ts), 5'h1F);
      wait_end(n);
      chk("frame_latency", n, LEN + 1);
      check_image("image_frame");
      decrypt_check(8'h7E, 7, tap_of(3'(ts)));
    end

    pulse_init(8'h7E, 4'd7, 3'd6, 5'h1F);
    wait_end(n);
    chk("err_lat_tap", n, 1);
    chk("err_flag_tap", err, 1);
    repeat (3) @(negedge clk);
    pulse_init(8'h7E, 4'd7, 3'd0, 5'h00);
    wait_end(n);
    chk("err_lat_seed", n, 1);
    chk("err_flag_seed", err, 1);
    repeat (3) @(negedge clk);
    pulse_init(8'h7E, 4'd4, 3'd0, 5'h1F);
    wait_end(n);
    chk("err_lat_prelen", n, 1);
    chk("err_flag_prelen", err, 1);
    repeat (3) @(negedge clk);

    @(posedge clk);
    #2;
    pulse_init(8'h7E, 4'd7, 3'd3, 5'h1F);
    repeat (20) @(posedge clk);
    #2;
    pulse_init(8'h7E, 4'd7, 3'd3, 5'h0A);
    wait_end(n);
    chk("restart_latency", n, LEN + 1);
    check_image("image_restart");

    @(posedge clk);
    #2;
    pulse_init(8'h55, 4'd9, 3'd5, 5'h1F);
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", bus.wr_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_raddr", bus.raddr, 0);
    chk("arst_waddr", bus.waddr, CT_BASE);
    chk("arst_data_in", bus.data_in, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
    pulse_init(8'h55, 4'd9, 3'd5, 5'h1F);
    wait_end(n);
    chk("post_reset_latency", n, LEN + 1);
    check_image("image_post_reset");

    pulse_init(8'h7E, 4'd6, 3'd1, 5'h13);
    wait_end(n);
    chk("b2b_first", n, LEN + 1);
    pulse_init(8'hA3, 4'd11, 3'd4, 5'h07);
    wait_end(n);
    chk("b2b_second", n, LEN + 1);
    check_image("image_b2b");

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < LEN; i++) pt_mem[i] = 8'($urandom);
      rp = 8'($urandom);
      rl = 4'(5 + $urandom_range(0, 10));
      rt = 3'($urandom_range(0, 5));
      rs = 5'($urandom_range(1, 31));
      @(posedge clk);
      #2;
      pulse_init(rp, rl, rt, rs);
      wait_end(n);
      chk("rand_latency", n, LEN + 1);
      check_image("image_rand");
      decrypt_check(rp, int'(rl), tap_of(rt));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
